id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and branch flush for the 5-stage RV64 pipeline.
- Sits between decode and execute.
- Its IDEX_rs1/IDEX_rs2/IDEX_rd and control outputs feed the EX-stage forwarding unit and the EX/MEM register.
- Drives PC/IF-ID write enables and keeps saturating stall/flush performance counters.

Parameters:
XLEN, 64, datapath width of operands, immediate and PC
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 clears state at the rising edge of clk)
IFID_rs1, IFID_rs2, IFID_rd  input  5 each  register fields of the decoded instruction
IFID_rs1_data, IFID_rs2_data  input  XLEN each  register-file read data
IFID_imm, IFID_PC  input  XLEN each  immediate and PC of the decoded instruction
IFID_funct4  input  4  {funct7[5], funct3}
ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc  input  1 each  decoder control bits
ID_ALUOp  input  2  decoder ALU op class
branch_taken  input  1  EX-stage branch resolved taken; flush request
IDEX_rs1, IDEX_rs2, IDEX_rd  output  5 each  registered register fields
IDEX_rs1_data, IDEX_rs2_data, IDEX_imm, IDEX_PC  output  XLEN each  registered operands
IDEX_funct4  output  4  registered funct bits
IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_Branch, IDEX_ALUSrc  output  1 each  registered control
IDEX_ALUOp  output  2  registered ALU op
stall  output  1  combinational load-use stall indication
PC_write  output  1  PC update enable
IFID_write  output  1  IF/ID register load enable
IFID_flush  output  1  IF/ID register clear request
stall_cnt, flush_cnt  output  CNT_W each  saturating event counters

Behaviour:
- Reset (reset==0 at a clk edge): every IDEX_* output becomes 0, counters become 0, and the state becomes RUN. Reset has the highest priority and aborts any in-progress stall.
- Hazard detect (combinational): lu_hit = IDEX_MemRead && IDEX_rd!=0 && (IDEX_rd==IFID_rs1 || IDEX_rd==IFID_rs2).
- Priority per cycle: reset > branch_taken > lu_hit > normal.
- stall = lu_hit && !branch_taken.
- PC_write = IFID_write = !stall.
- IFID_flush = branch_taken.
- Normal cycle: all IFID_*/ID_* inputs are registered into IDEX_* at the edge. Latency is 1 cycle.
- Bubble (stall or flush): at the edge, every IDEX control bit is 0, ALUOp=0, and IDEX_rs1=IDEX_rs2=IDEX_rd=0. Data fields are don't-care; implement them as 0.
  - rd must be zeroed because downstream forwarding matches EX/MEM rd without qualifying on RegWrite.
- State machine (for counting and single-cycle guarantee):
  - RUN: lu_hit && !branch_taken -> STALL (stall_cnt+1). branch_taken -> RUN (flush_cnt+1).
  - STALL: the bubble is now in ID/EX, so IDEX_MemRead=0 and lu_hit is necessarily 0. Normal load occurs and the state returns to RUN. branch_taken in STALL flushes, counts, and returns to RUN.
- A load-use stall always lasts exactly 1 cycle.
- Back-to-back loads feeding each other stall once per dependent pair.
- Counters saturate at all-ones and never wrap.
- Simultaneous branch_taken and lu_hit: flush wins. stall=0, PC_write=1, only flush_cnt increments.
- No internal storage beyond the ID/EX register, the state bit, and the two counters.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> all IDEX_* =0, stall_cnt=flush_cnt=0. Release -> next edge registers inputs, e.g. IFID_rd=5 appears as IDEX_rd=5 after 1 cycle.
- Load-use: ld x5 (ID_MemRead=1, rd=5), then add x6,x5,x7 in ID -> stall=1, PC_write=0, IFID_write=0 for exactly one cycle. IDEX is a bubble with IDEX_rd=0, RegWrite=0. The next cycle registers the add (IDEX_rs1=5). stall_cnt=1.
- No false stall: ld x0, then use of x0 -> stall=0. ld x5, then add x6,x7,x8 -> stall=0.
- Branch flush: branch_taken=1 with a valid instruction in ID -> IFID_flush=1, IDEX bubble (IDEX_rd=0), flush_cnt=1, PC_write=1.
- Simultaneous: lu_hit and branch_taken in the same cycle -> stall=0, bubble inserted, flush_cnt increments, stall_cnt unchanged.
- Saturation and reset mid-stall: force stall_cnt to all-ones (CNT_W=4 build) and trigger a stall -> stays at 15. Assert reset=0 during STALL -> state RUN, outputs 0, no further stall cycle.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: IF/ID and decoder fields in, registered ID/EX fields,
// hazard controls and performance counters out.
interface id_ex_stage_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_rs1, IFID_rs2, IFID_rd;
    logic [XLEN-1:0]  IFID_rs1_data, IFID_rs2_data, IFID_imm, IFID_PC;
    logic [3:0]       IFID_funct4;
    logic             ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc;
    logic [1:0]       ID_ALUOp;
    logic             branch_taken;

    logic [4:0]       IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [XLEN-1:0]  IDEX_rs1_data, IDEX_rs2_data, IDEX_imm, IDEX_PC;
    logic [3:0]       IDEX_funct4;
    logic             IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_Branch, IDEX_ALUSrc;
    logic [1:0]       IDEX_ALUOp;
    logic             stall, PC_write, IFID_write, IFID_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output IFID_rs1, IFID_rs2, IFID_rd, IFID_rs1_data, IFID_rs2_data, IFID_imm, IFID_PC,
               IFID_funct4, ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch,
               ID_ALUSrc, ID_ALUOp, branch_taken,
        input  IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm, IDEX_PC,
               IDEX_funct4, IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite,
               IDEX_Branch, IDEX_ALUSrc, IDEX_ALUOp, stall, PC_write, IFID_write, IFID_flush,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  IFID_rs1, IFID_rs2, IFID_rd, IFID_rs1_data, IFID_rs2_data, IFID_imm, IFID_PC,
               IFID_funct4, ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch,
               ID_ALUSrc, ID_ALUOp, branch_taken,
        output IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm, IDEX_PC,
               IDEX_funct4, IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite,
               IDEX_Branch, IDEX_ALUSrc, IDEX_ALUOp, stall, PC_write, IFID_write, IFID_flush,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush bubble insertion and
// saturating stall/flush event counters.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);
    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

    typedef struct packed {
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] rs1_data, rs2_data, imm, pc;
        logic [3:0]      funct4;
        logic            reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src;
        logic [1:0]      alu_op;
    } idex_t;

    state_e           state_q, state_d;
    idex_t            idex_q, idex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu_hit, stall_c, bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // A bubble always follows a stall, so gating on RUN only makes the one-cycle limit explicit.
    always_comb begin
        lu_hit  = (state_q == RUN) && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                  ((idex_q.rd == bus.IFID_rs1) || (idex_q.rd == bus.IFID_rs2));
        stall_c = lu_hit && !bus.branch_taken;
        bubble  = lu_hit || bus.branch_taken;
    end

    always_comb begin
        idex_d = '0;
        if (!bubble) begin
            idex_d.rs1        = bus.IFID_rs1;
            idex_d.rs2        = bus.IFID_rs2;
            idex_d.rd         = bus.IFID_rd;
            idex_d.rs1_data   = bus.IFID_rs1_data;
            idex_d.rs2_data   = bus.IFID_rs2_data;
            idex_d.imm        = bus.IFID_imm;
            idex_d.pc         = bus.IFID_PC;
            idex_d.funct4     = bus.IFID_funct4;
            idex_d.reg_write  = bus.ID_RegWrite;
            idex_d.mem_to_reg = bus.ID_MemtoReg;
            idex_d.mem_read   = bus.ID_MemRead;
            idex_d.mem_write  = bus.ID_MemWrite;
            idex_d.branch     = bus.ID_Branch;
            idex_d.alu_src    = bus.ID_ALUSrc;
            idex_d.alu_op     = bus.ID_ALUOp;
        end
    end

    always_comb begin
        state_d     = RUN;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.branch_taken) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (lu_hit) begin
            state_d     = STALL;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            idex_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.IDEX_rs1      = idex_q.rs1;
    assign bus.IDEX_rs2      = idex_q.rs2;
    assign bus.IDEX_rd       = idex_q.rd;
    assign bus.IDEX_rs1_data = idex_q.rs1_data;
    assign bus.IDEX_rs2_data = idex_q.rs2_data;
    assign bus.IDEX_imm      = idex_q.imm;
    assign bus.IDEX_PC       = idex_q.pc;
    assign bus.IDEX_funct4   = idex_q.funct4;
    assign bus.IDEX_RegWrite = idex_q.reg_write;
    assign bus.IDEX_MemtoReg = idex_q.mem_to_reg;
    assign bus.IDEX_MemRead  = idex_q.mem_read;
    assign bus.IDEX_MemWrite = idex_q.mem_write;
    assign bus.IDEX_Branch   = idex_q.branch;
    assign bus.IDEX_ALUSrc   = idex_q.alu_src;
    assign bus.IDEX_ALUOp    = idex_q.alu_op;
    assign bus.stall         = stall_c;
    assign bus.PC_write      = !stall_c;
    assign bus.IFID_write    = !stall_c;
    assign bus.IFID_flush    = bus.branch_taken;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
endmodule
